// File: rtl/counterdown16_wrap_capture.sv
// counterdown16_wrap_capture
//
// Purpose:
//   Watches the sampled value of a free-running 16-bit down counter. It
//   extends that value with an epoch (wrap) counter and flags underflow
//   wraps and compare matches. It also hands out coherent
//   {wrap_count, count} snapshots over a valid/ready handshake.
//
// Ports:
//   clock0       in   single clock, rising edge
//   reset        in   synchronous, active-high
//   count_in     in   [WIDTH]      current down-counter value
//   compare      in   [WIDTH]      match value (quasi-static)
//   capture_req  in   1            one-cycle snapshot request
//   snap_valid   out  1            snapshot available
//   snap_ready   in   1            consumer accepts the snapshot
//   snap_data    out  [EXT+WIDTH]  snapshot {wrap_count, count}
//   wrap_pulse   out  1            one-cycle pulse on underflow wrap
//   match_pulse  out  1            one-cycle pulse when count newly == compare
//   wrap_count   out  [EXT]        underflows since reset, modulo 2^EXT
//   overrun      out  1            sticky: a capture request was dropped
module counterdown16_wrap_capture #(
  parameter int WIDTH     = 16,
  parameter int EXT_WIDTH = 16
) (
  input  logic                       clock0,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           count_in,
  input  logic [WIDTH-1:0]           compare,
  input  logic                       capture_req,
  output logic                       snap_valid,
  input  logic                       snap_ready,
  output logic [EXT_WIDTH+WIDTH-1:0] snap_data,
  output logic                       wrap_pulse,
  output logic                       match_pulse,
  output logic [EXT_WIDTH-1:0]       wrap_count,
  output logic                       overrun
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;

  // History of the previous sample. prev_valid stays low for the first
  // edge after reset, so detection never compares against the reset value.
  logic [WIDTH-1:0]     prev;
  logic                 prev_valid;

  logic                 wrap_det;
  logic                 match_det;
  logic [EXT_WIDTH-1:0] wrap_count_next;
  logic                 handshake;
  logic                 accept;
  logic                 drop;

  always_comb begin
    wrap_det        = 1'b0;
    match_det       = 1'b0;
    wrap_count_next = wrap_count;
    handshake       = 1'b0;
    accept          = 1'b0;
    drop            = 1'b0;

    // Only a true 0 -> all-ones step is an underflow. A jump to all-ones
    // from any other value (e.g. upstream reset) is ignored.
    wrap_det  = prev_valid && (prev == ZERO) && (count_in == ALL_ONES);

    // Edge detect, so a counter stalled on the compare value fires once.
    match_det = prev_valid && (count_in == compare) && (prev != compare);

    // The snapshot takes the post-increment epoch, so a captured all-ones
    // count is never paired with the epoch from before the wrap.
    if (wrap_det) begin
      wrap_count_next = wrap_count + 1'b1;
    end

    handshake = snap_valid && snap_ready;
    accept    = capture_req && (!snap_valid || snap_ready);
    drop      = capture_req && snap_valid && !snap_ready;
  end

  // History register and event detection outputs.
  always_ff @(posedge clock0) begin
    if (reset) begin
      prev        <= '0;
      prev_valid  <= 1'b0;
      wrap_pulse  <= 1'b0;
      match_pulse <= 1'b0;
      wrap_count  <= '0;
    end else begin
      prev        <= count_in;
      prev_valid  <= 1'b1;
      wrap_pulse  <= wrap_det;
      match_pulse <= match_det;
      wrap_count  <= wrap_count_next;
    end
  end

  // Snapshot holding register. A new accept takes priority over a
  // handshake on the same edge, so the valid flag stays up and the
  // stream can run at one snapshot per cycle.
  always_ff @(posedge clock0) begin
    if (reset) begin
      snap_valid <= 1'b0;
      snap_data  <= '0;
      overrun    <= 1'b0;
    end else begin
      if (accept) begin
        snap_valid <= 1'b1;
        snap_data  <= {wrap_count_next, count_in};
      end else if (handshake) begin
        snap_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
